// File: rtl/trace_dump_unit.sv
// trace_dump_unit: circular retirement-trace buffer with halt/pc trigger,
// post-trigger window and a registered valid/ready dump port.
module trace_dump_unit #(
    parameter int W_PC      = 16,
    parameter int W_OP      = 8,
    parameter int W_DATA    = 32,
    parameter int W_REG     = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    localparam int W_REC    = 2 + W_REG + W_OP + W_PC + W_DATA,
    localparam int W_PTR    = $clog2(DEPTH),
    localparam int W_CNT    = W_PTR + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm_i,
    input  logic [1:0]        trig_mode_i,
    input  logic [W_PC-1:0]   trig_pc_i,
    input  logic              valid_i,
    input  logic [W_PC-1:0]   pc_i,
    input  logic [W_OP-1:0]   opcode_i,
    input  logic [W_DATA-1:0] result_i,
    input  logic              wb_en_i,
    input  logic [W_REG-1:0]  wb_reg_i,
    input  logic              br_taken_i,
    input  logic              hlt_i,
    input  logic              dump_ready_i,
    output logic              dump_valid_o,
    output logic [W_REC-1:0]  dump_data_o,
    output logic              dump_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [W_CNT-1:0]  count_o
);

    typedef enum logic [2:0] {IDLE, CAPTURE, POST, DUMP, DONE} state_t;

    localparam logic [W_CNT-1:0] FULL      = W_CNT'(DEPTH);
    localparam logic [W_CNT-1:0] POST_INIT = W_CNT'(POST_TRIG);
    localparam logic [W_CNT-1:0] ONE_C     = W_CNT'(1);
    localparam logic [W_PTR-1:0] ONE_P     = W_PTR'(1);

    state_t           state, state_nxt;
    logic [W_REC-1:0] mem [DEPTH];
    logic [W_PTR-1:0] wptr, wptr_nxt, rptr;
    logic [W_CNT-1:0] count, count_nxt, post_left, left;
    logic             overflow, dump_valid, dump_last;
    logic [W_REC-1:0] dump_data;
    logic             pc_hit, trig, wr, xfer, load, enter_dump;

    // Trigger qualification and per-cycle datapath strobes.
    always_comb begin
        pc_hit = valid_i && (pc_i == trig_pc_i);
        unique case (trig_mode_i)
            2'b01:   trig = pc_hit;
            2'b10:   trig = hlt_i || pc_hit;
            default: trig = hlt_i;
        endcase
        wr        = valid_i && (state == CAPTURE || state == POST);
        wptr_nxt  = wr ? wptr + ONE_P : wptr;
        count_nxt = (wr && count != FULL) ? count + ONE_C : count;
        xfer      = dump_valid && dump_ready_i;
        load      = (state == DUMP) && (!dump_valid || dump_ready_i)
                    && (left != '0);
    end

    // Next-state: arm, trigger, post window, dump completion.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (arm_i) state_nxt = CAPTURE;
            CAPTURE:    if (trig) state_nxt = (POST_TRIG == 0) ? DUMP : POST;
            POST:       if (hlt_i || (valid_i && post_left == ONE_C))
                            state_nxt = DUMP;
            DUMP:       if ((xfer && dump_last) || (!dump_valid && left == '0))
                            state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    assign enter_dump = (state != DUMP) && (state_nxt == DUMP);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Trace storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= {br_taken_i, wb_en_i, wb_reg_i,
                              opcode_i, pc_i, result_i};
    end

    // Pointers, occupancy, post window and registered dump output.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            post_left  <= '0;
            left       <= '0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            dump_data  <= '0;
        end else begin
            if (arm_i && (state == IDLE || state == DONE)) begin
                wptr     <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else if (wr) begin
                wptr  <= wptr_nxt;
                count <= count_nxt;
                if (count == FULL) overflow <= 1'b1;
            end
            if (state == CAPTURE)
                post_left <= POST_INIT;
            else if (state == POST && wr)
                post_left <= post_left - ONE_C;
            if (enter_dump) begin
                rptr <= (count_nxt == FULL) ? wptr_nxt : '0;
                left <= count_nxt;
            end else if (load) begin
                dump_data  <= mem[rptr];
                dump_valid <= 1'b1;
                dump_last  <= (left == ONE_C);
                rptr       <= rptr + ONE_P;
                left       <= left - ONE_C;
            end else if (xfer) begin
                dump_valid <= 1'b0;
                dump_last  <= 1'b0;
            end
        end
    end

    assign dump_valid_o = dump_valid;
    assign dump_data_o  = dump_data;
    assign dump_last_o  = dump_last;
    assign busy_o       = (state == CAPTURE) || (state == POST) || (state == DUMP);
    assign done_o       = (state == DONE);
    assign overflow_o   = overflow;
    assign count_o      = count;

endmodule

// File: tb/tb_trace_dump_unit.sv
// tb_trace_dump_unit: directed and randomized checks of trace_dump_unit
// against a queue-based capture/dump reference model.
module tb_trace_dump_unit;

    logic        clk = 1'b0;
    logic        reset, arm_i, valid_i, wb_en_i, br_taken_i, hlt_i, dump_ready_i;
    logic [1:0]  trig_mode_i;
    logic [15:0] trig_pc_i, pc_i;
    logic [7:0]  opcode_i;
    logic [31:0] result_i;
    logic [3:0]  wb_reg_i;

    logic        dv0, dl0, busy0, done0, ovf0;
    logic        dv2, dl2, busy2, done2, ovf2;
    logic [61:0] dd0, dd2;
    logic [3:0]  cnt0, cnt2;

    bit          sel = 1'b0;
    logic        dv, dl, busy, done, ovf;
    logic [61:0] dd;
    logic [3:0]  cnt;

    int total = 0;
    int bad   = 0;

    logic [61:0] cap_q[$];
    bit          m_cap;
    bit          m_post_ph;
    int          m_post;

    always #5 clk = ~clk;

    trace_dump_unit #(.DEPTH(8), .POST_TRIG(0)) dut0 (
        .clk(clk), .reset(reset), .arm_i(arm_i), .trig_mode_i(trig_mode_i),
        .trig_pc_i(trig_pc_i), .valid_i(valid_i), .pc_i(pc_i),
        .opcode_i(opcode_i), .result_i(result_i), .wb_en_i(wb_en_i),
        .wb_reg_i(wb_reg_i), .br_taken_i(br_taken_i), .hlt_i(hlt_i),
        .dump_ready_i(dump_ready_i), .dump_valid_o(dv0), .dump_data_o(dd0),
        .dump_last_o(dl0), .busy_o(busy0), .done_o(done0),
        .overflow_o(ovf0), .count_o(cnt0)
    );

    trace_dump_unit #(.DEPTH(8), .POST_TRIG(2)) dut2 (
        .clk(clk), .reset(reset), .arm_i(arm_i), .trig_mode_i(trig_mode_i),
        .trig_pc_i(trig_pc_i), .valid_i(valid_i), .pc_i(pc_i),
        .opcode_i(opcode_i), .result_i(result_i), .wb_en_i(wb_en_i),
        .wb_reg_i(wb_reg_i), .br_taken_i(br_taken_i), .hlt_i(hlt_i),
        .dump_ready_i(dump_ready_i), .dump_valid_o(dv2), .dump_data_o(dd2),
        .dump_last_o(dl2), .busy_o(busy2), .done_o(done2),
        .overflow_o(ovf2), .count_o(cnt2)
    );

    assign dv   = sel ? dv2   : dv0;
    assign dl   = sel ? dl2   : dl0;
    assign dd   = sel ? dd2   : dd0;
    assign busy = sel ? busy2 : busy0;
    assign done = sel ? done2 : done0;
    assign ovf  = sel ? ovf2  : ovf0;
    assign cnt  = sel ? cnt2  : cnt0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_dv"},   64'(dv),   64'd0);
        check({tag, "_dl"},   64'(dl),   64'd0);
        check({tag, "_dd"},   64'(dd),   64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ovf"},  64'(ovf),  64'd0);
        check({tag, "_cnt"},  64'(cnt),  64'd0);
    endtask

    task automatic model_arm();
        cap_q.delete();
        m_cap     = 1'b1;
        m_post_ph = 1'b0;
        m_post    = 0;
    endtask

    task automatic arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        model_arm();
    endtask

    // One valid retirement record; the model decides whether it is kept.
    task automatic send(input logic [15:0] pc, input bit hlt, input bit arm);
        logic [61:0] rec;
        bit hm, pm;
        int post_n;
        post_n       = sel ? 2 : 0;
        br_taken_i   = 1'($urandom);
        wb_en_i      = 1'($urandom);
        wb_reg_i     = 4'($urandom);
        opcode_i     = 8'($urandom);
        result_i     = $urandom;
        pc_i         = pc;
        valid_i      = 1'b1;
        hlt_i        = hlt;
        arm_i        = arm;
        rec = {br_taken_i, wb_en_i, wb_reg_i, opcode_i, pc_i, result_i};
        hm = (trig_mode_i != 2'b01);
        pm = (trig_mode_i == 2'b01) || (trig_mode_i == 2'b10);
        if (m_cap) begin
            cap_q.push_back(rec);
            if (m_post_ph) begin
                m_post--;
                if (m_post == 0 || hlt) m_cap = 1'b0;
            end else if ((hm && hlt) || (pm && pc == trig_pc_i)) begin
                if (post_n == 0) m_cap = 1'b0;
                else begin
                    m_post_ph = 1'b1;
                    m_post    = post_n;
                end
            end
        end
        tick();
        valid_i = 1'b0;
        hlt_i   = 1'b0;
        arm_i   = 1'b0;
    endtask

    task automatic idle_cycle();
        valid_i = 1'b0;
        pc_i    = 16'($urandom);
        tick();
    endtask

    // Collect the dump and compare with the last DEPTH captured records.
    task automatic drain(input int stall_at, input int stall_len, input bit rnd,
                         input int exp_cyc, input string tag);
        logic [63:0] got[$];
        int cyc = 0, stalls = 0, lastpos = -1, n, k, st;
        bit fin = 1'b0, pv = 1'b0, pr = 1'b1, pl = 1'b0, r;
        logic [61:0] pd = '0;
        n  = cap_q.size();
        k  = (n > 8) ? 8 : n;
        st = n - k;
        while (!fin && cyc < 300) begin
            if (pv && !pr) begin
                check({tag, "_hold_v"}, 64'(dv), 64'd1);
                check({tag, "_hold_d"}, 64'(dd), 64'(pd));
                check({tag, "_hold_l"}, 64'(dl), 64'(pl));
            end
            if (rnd) r = 1'($urandom);
            else if (got.size() == stall_at && stalls < stall_len) begin
                r = 1'b0;
                stalls++;
            end else r = 1'b1;
            dump_ready_i = r;
            if (dv && r) begin
                got.push_back(64'(dd));
                if (dl) begin
                    fin = 1'b1;
                    lastpos = got.size() - 1;
                end
            end
            pv = dv; pd = dd; pl = dl; pr = r;
            tick();
            cyc++;
        end
        dump_ready_i = 1'b0;
        check({tag, "_end"},  64'(fin), 64'd1);
        check({tag, "_num"},  64'(got.size()), 64'(k));
        for (int i = 0; i < got.size() && i < k; i++)
            check({tag, "_data"}, got[i], 64'(cap_q[st+i]));
        check({tag, "_last"}, 64'(lastpos), 64'(k - 1));
        check({tag, "_dv_off"}, 64'(dv), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_ovf"},  64'(ovf), 64'(n > 8));
        check({tag, "_cnt"},  64'(cnt), 64'(k));
        if (exp_cyc >= 0) check({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
    endtask

    initial begin
        reset = 1'b1; arm_i = 1'b0; valid_i = 1'b0; hlt_i = 1'b0;
        dump_ready_i = 1'b0; trig_mode_i = 2'b00; trig_pc_i = '0;
        pc_i = '0; opcode_i = '0; result_i = '0; wb_en_i = 1'b0;
        wb_reg_i = '0; br_taken_i = 1'b0;
        tick(); tick();
        sel = 1'b0; chk_idle("rst0");
        sel = 1'b1; chk_idle("rst2");
        sel = 1'b0;
        reset = 1'b0;

        // arm with halt in IDLE: capture starts, no trigger
        arm_i = 1'b1; hlt_i = 1'b1;
        tick();
        arm_i = 1'b0; hlt_i = 1'b0;
        model_arm();
        check("arm_busy", 64'(busy), 64'd1);
        check("arm_done", 64'(done), 64'd0);
        tick();
        check("arm_stay", 64'(busy), 64'd1);
        check("arm_cnt",  64'(cnt),  64'd0);

        // pc 0..4, halt on 4; arm on pc 2 is ignored while capturing
        for (int i = 0; i < 5; i++) send(16'(i), i == 4, i == 2);
        drain(-1, 0, 1'b0, 6, "r22");

        // wrap: pc 0..10, oldest three overwritten
        arm();
        for (int i = 0; i < 11; i++) send(16'(i), i == 10, 1'b0);
        drain(-1, 0, 1'b0, 9, "r23");

        // consumer stalls 3 cycles after the 2nd transfer
        arm();
        for (int i = 0; i < 6; i++) send(16'(i), i == 5, 1'b0);
        drain(2, 3, 1'b0, -1, "r25");

        // trigger with nothing captured: straight to DONE
        arm();
        hlt_i = 1'b1;
        tick();
        hlt_i = 1'b0;
        m_cap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("empty_dv", 64'(dv), 64'd0);
            tick();
        end
        check("empty_done", 64'(done), 64'd1);
        check("empty_cnt",  64'(cnt),  64'd0);

        // reset mid-dump, then rerun the basic case
        arm();
        for (int i = 0; i < 5; i++) send(16'(i), i == 4, 1'b0);
        dump_ready_i = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dump_ready_i = 1'b0;
        chk_idle("r26");
        arm();
        for (int i = 0; i < 5; i++) send(16'(i), i == 4, 1'b0);
        drain(-1, 0, 1'b0, 6, "r26b");

        // pc-match trigger with a 2-record post window
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sel = 1'b1;
        trig_mode_i = 2'b01;
        trig_pc_i   = 16'd6;
        arm();
        for (int i = 0; i < 10; i++) send(16'(i), 1'b0, 1'b0);
        drain(-1, 0, 1'b0, -1, "r24");
        sel = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // randomized rounds: random modes, pcs, gaps and ready
        for (int r = 0; r < 8; r++) begin
            logic [15:0] pcs[$];
            int n;
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) pcs.push_back(16'($urandom));
            trig_mode_i = 2'($urandom_range(0, 3));
            trig_pc_i   = pcs[n-1];
            arm();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) idle_cycle();
                send(pcs[i], i == n - 1, 1'b0);
            end
            drain(-1, 0, 1'b1, -1, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_dump_unit.md
TRACE_DUMP_UNIT -- requirements
Module: trace_dump_unit

Interface
REQ-001 The block SHALL have these parameters:
- W_PC, 16, pc width.
- W_OP, 8, opcode field width.
- W_DATA, 32, result width.
- W_REG, 4, writeback register index width.
- DEPTH, 16, trace buffer entries (power of 2, >=2).
- POST_TRIG, 4, records captured after trigger (0..DEPTH-1).

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- arm_i  in  1  start/restart capture.
- trig_mode_i  in  2  00 halt, 01 pc match, 10 halt or pc match, 11 reserved (treated as 00).
- trig_pc_i  in  W_PC  pc-match value.
- valid_i  in  1  retirement record valid this cycle.
- pc_i  in  W_PC  record pc.
- opcode_i  in  W_OP  record opcode.
- result_i  in  W_DATA  record result.
- wb_en_i  in  1  record writes a register.
- wb_reg_i  in  W_REG  record destination register.
- br_taken_i  in  1  record branch taken.
- hlt_i  in  1  processor halt.
- dump_ready_i  in  1  consumer accepts dump record.
- dump_valid_o  out  1  dump record present.
- dump_data_o  out  W_REC  {br_taken, wb_en, wb_reg, opcode, pc, result}, with W_REC = 2+W_REG+W_OP+W_PC+W_DATA.
- dump_last_o  out  1  final dump record.
- busy_o  out  1  state is CAPTURE, POST or DUMP.
- done_o  out  1  state is DONE.
- overflow_o  out  1  oldest records overwritten.
- count_o  out  clog2(DEPTH)+1  records held.

Function
REQ-003 The FSM SHALL have states IDLE, CAPTURE, POST, DUMP, DONE.
REQ-004 In IDLE or DONE, arm_i=1 SHALL clear the write pointer, count_o and overflow_o and enter CAPTURE next cycle; arm_i SHALL be ignored in all other states.
REQ-005 In CAPTURE/POST, valid_i=1 SHALL write the record at the write pointer on that edge; the pointer SHALL wrap modulo DEPTH.
REQ-006 count_o SHALL increment per write and saturate at DEPTH; a write while count_o==DEPTH SHALL set overflow_o, and overflow_o SHALL stay set until re-arm or reset.
REQ-007 valid_i SHALL be ignored in IDLE, DUMP and DONE.
REQ-008 The trigger SHALL be hlt_i (modes 00/10) or valid_i with pc_i==trig_pc_i (modes 01/10), evaluated only in CAPTURE.
REQ-009 On a trigger in CAPTURE, a same-cycle valid record SHALL be captured; the FSM SHALL then enter POST with POST_TRIG remaining, or DUMP directly if POST_TRIG=0.
REQ-010 In POST, each captured record SHALL decrement the remaining count; the write that reaches 0 SHALL move the FSM to DUMP next cycle.
REQ-011 hlt_i in POST SHALL move the FSM to DUMP next cycle, with a same-cycle valid record still captured.
REQ-012 On DUMP entry, the read pointer SHALL be the oldest entry: the write pointer if count_o==DEPTH, else 0.
REQ-013 dump_valid_o SHALL rise the cycle after DUMP entry, with one cycle of registered read latency.
REQ-014 Records SHALL be presented oldest first; a transfer SHALL occur on dump_valid_o & dump_ready_i, advancing the read pointer with wrap.
REQ-015 While dump_valid_o=1 and dump_ready_i=0, dump_data_o and dump_last_o SHALL hold stable; throughput SHALL be one record per cycle under continuous ready.
REQ-016 dump_last_o SHALL assert with the count_o-th record; after its transfer the FSM SHALL enter DONE and deassert dump_valid_o the next cycle.
REQ-017 If count_o==0 on DUMP entry, the FSM SHALL go to DONE without asserting dump_valid_o.
REQ-018 count_o SHALL hold its final capture value during DUMP and DONE.

Reset
REQ-019 reset=1 SHALL, on the next edge, enter IDLE from any state, including mid-dump, and drive every output to 0; buffer contents need not be cleared.
REQ-020 reset SHALL take priority over arm_i, triggers and handshakes in the same cycle.

Verification (DEPTH=8, POST_TRIG=0 unless stated)
REQ-021 Reset -> all outputs 0, state IDLE; arm_i with hlt_i high in the same IDLE cycle -> CAPTURE only, no trigger.
REQ-022 Arm, then records pc=0..4 with hlt_i on the pc=4 cycle, ready=1 -> 5 transfers pc 0,1,2,3,4, last on pc=4, overflow_o=0, count_o=5, done_o=1.
REQ-023 Arm, records pc=0..10, hlt_i with pc=10 -> 8 transfers pc 3..10, overflow_o=1, count_o=8.
REQ-024 Mode 01, trig_pc_i=6, POST_TRIG=2, records pc=0..9 -> capture stops after pc=8, dump pc 1..8, last on pc=8.
REQ-025 dump_ready_i low for 3 cycles after the 2nd transfer -> data held stable, full sequence without skip or duplicate.
REQ-026 Reset asserted mid-dump -> dump_valid_o=0 and state IDLE next cycle; re-arm and REQ-022 stimulus reproduce REQ-022 results.
